serial_addsub_unit: RTL and testbench
=====================================

# serial_addsub_unit

Parametrised, multi-cycle add/subtract unit with ARM-style NZCV flags. It processes operands DIGIT bits per clock, so datapath width can grow without widening the carry chain. It is the generalised successor of the team's fixed 4-bit subtractor: it supports any width, adds an add mode, computes correct N/C/V flags, and uses a start/done handshake. It sits in the lab ALU datapath, between the operand registers and the flag/result register file.

## Interface

Parameters:
- WIDTH, 8, operand and result width; must be a multiple of DIGIT and at least 2.
- DIGIT, 2, bits processed per cycle; must be at least 1.

Ports:
- clk, input, 1, single clock; all state updates on its rising edge.
- rst, input, 1, synchronous, active-high reset.
- start, input, 1, request pulse; accepted only when ready=1.
- op, input, 1, 0 = add (a+b), 1 = subtract (a-b); sampled with start.
- a, input, WIDTH, operand A; sampled with start.
- b, input, WIDTH, operand B; sampled with start.
- ready, output, 1, high in IDLE.
- done, output, 1, one-cycle pulse when result and flags update.
- result, output, WIDTH, registered result; holds between operations.
- flags, output, 4, registered flags with bit order [0]=N, [1]=Z, [2]=C, [3]=V; holds between operations.

## Operation

- STEPS = WIDTH/DIGIT.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start=1. Latch a, latch op, and latch b (or ~b when op=1). Set the carry register to op (1 for subtract, 0 for add). Clear the step counter.
  - RUN: each cycle, add the lowest DIGIT bits of the latched operands plus the carry register. Shift the sum digit into the top of the result shift register. Shift both operands right by DIGIT. Update the carry register. Increment the counter.
  - RUN -> DONE after STEPS RUN cycles.
  - DONE -> IDLE unconditionally after one cycle.
- In DONE, the following registers are written and done is pulsed:
  - result = assembled sum, modulo 2^WIDTH.
  - N = result[WIDTH-1].
  - Z = (result == 0).
  - C = final carry out. For add this is the unsigned overflow. For subtract, C=1 means no borrow (a >= b unsigned).
  - V = carry into the MSB XOR carry out of the MSB, i.e. signed overflow.
- start while ready=0 is ignored; there is no queueing.
- a, b and op may change freely after the accept cycle.
- rst at any time, including mid-RUN:
  - Forces IDLE and aborts the current operation.
  - Clears result to 0, flags to 4'b0000 and done to 0. ready=1 in the cycle after rst deasserts.
  - rst takes priority over start in the same cycle.

## Timing

- Reset values: ready=1, done=0, result=0, flags=0.
- start accepted at rising edge k:
  - ready=0 during cycles k+1 through k+STEPS+1.
  - done=1, with the new result and flags visible, in cycle k+STEPS+1.
  - ready=1 from cycle k+STEPS+2.
- Latency from accept to done is STEPS+1 cycles. Throughput is one operation per STEPS+2 cycles.
- A back-to-back start can be accepted at the first cycle ready=1 after done.
- result and flags change only in the DONE cycle or on reset. They never show intermediate values.
- DIGIT=WIDTH is legal: one RUN cycle, latency 2.

## Structure

- Package alu_pkg holds:
  - Flag index constants FLAG_N=0, FLAG_Z=1, FLAG_C=2, FLAG_V=3.
  - OP_ADD=1'b0 and OP_SUB=1'b1.
  - The state enum (IDLE, RUN, DONE).
- Sub-module digit_adder: combinational DIGIT-bit adder.
  - Inputs x, y, cin.
  - Outputs sum, cout, and c_msb (carry into the top bit), used for V on the final digit.
- The top level holds the FSM, counter, shift registers, carry register and output registers.

## Test plan

All scenarios use WIDTH=8, DIGIT=2.

- Sub 0x05-0x03 -> result 0x02, flags 4'b0100 (C=1). done in exactly cycle k+5. ready=0 during cycles k+1 to k+5.
- Sub 0x03-0x05 -> result 0xFE, flags 4'b0001 (N=1, C=0 because of borrow).
- Sub 0x80-0x01 -> result 0x7F, flags 4'b1100 (C=1, V=1). Add 0x7F+0x01 -> result 0x80, flags 4'b1001 (N=1, V=1).
- Add 0xFF+0x01 -> result 0x00, flags 4'b0110 (Z=1, C=1). Sub 0x5A-0x5A -> result 0x00, flags 4'b0110.
- start re-pulsed with different operands during RUN -> ignored; first operation's result delivered unchanged. rst asserted in the 2nd RUN cycle -> next cycle ready=1, result=0, flags=0, and no done pulse.
- Randomised sweep over WIDTH in {4, 8, 16} and DIGIT in {1, 2, WIDTH} against a reference model: result and all four flags must match for every operation.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and types for the serial add/subtract unit.
//   FLAG_*  : bit positions of N, Z, C and V inside the 4-bit flags word
//   OP_*    : encoding of the op input
//   state_t : control states of the serial sequencer
package alu_pkg;

   localparam int unsigned FLAG_N = 0;
   localparam int unsigned FLAG_Z = 1;
   localparam int unsigned FLAG_C = 2;
   localparam int unsigned FLAG_V = 3;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit adder slice.
//   x, y  : operand digits
//   cin   : carry into the digit
//   sum   : sum digit
//   cout  : carry out of the top bit
//   c_msb : carry into the top bit (for signed overflow on the last digit)
module digit_adder #(
   parameter int unsigned DIGIT = 2
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             cin,
   output logic [DIGIT-1:0] sum,
   output logic             cout,
   output logic             c_msb
);

   localparam int unsigned SW = DIGIT + 1;

   logic [SW-1:0] full;

   always_comb begin
      full  = SW'(x) + SW'(y) + SW'(cin);
      sum   = full[DIGIT-1:0];
      cout  = full[DIGIT];
      // sum bit = x ^ y ^ carry_in, so the carry into the top bit falls out directly
      c_msb = x[DIGIT-1] ^ y[DIGIT-1] ^ full[DIGIT-1];
   end

endmodule

// File: rtl/serial_addsub_unit.sv
// Multi-cycle add/subtract unit producing NZCV flags, DIGIT bits per clock.
//   clk, rst : clock, synchronous active-high reset
//   start    : request, accepted while ready=1 (op, a, b sampled with it)
//   op       : 0 = a+b, 1 = a-b
//   ready    : unit idle and able to accept start
//   done     : one-cycle pulse when result/flags update
//   result   : registered sum, held between operations
//   flags    : registered {V,C,Z,N}, held between operations
module serial_addsub_unit
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   localparam int unsigned STEPS = WIDTH / DIGIT;
   localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] opa_q, opb_q, res_sr_q;
   logic             carry_q;
   logic [CNT_W-1:0] cnt_q;

   logic [DIGIT-1:0] dsum;
   logic             dcout, dcmsb;
   logic             last_c;
   logic [WIDTH-1:0] res_next_c;

   digit_adder #(.DIGIT(DIGIT)) u_digit (
      .x     (opa_q[DIGIT-1:0]),
      .y     (opb_q[DIGIT-1:0]),
      .cin   (carry_q),
      .sum   (dsum),
      .cout  (dcout),
      .c_msb (dcmsb)
   );

   assign last_c     = (cnt_q == CNT_W'(STEPS - 1));
   // New digit enters at the top; after STEPS shifts the word is in place
   assign res_next_c = WIDTH'({dsum, res_sr_q} >> DIGIT);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last_c) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         ready    <= 1'b1;
         done     <= 1'b0;
         result   <= '0;
         flags    <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         res_sr_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         ready <= (state_d == IDLE);
         done  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  opa_q   <= a;
                  // Subtract as a + ~b + 1: the +1 rides in as the initial carry
                  opb_q   <= (op == OP_SUB) ? ~b : b;
                  carry_q <= (op != OP_ADD);
                  cnt_q   <= '0;
               end
            end
            RUN: begin
               opa_q    <= WIDTH'({DIGIT'(0), opa_q} >> DIGIT);
               opb_q    <= WIDTH'({DIGIT'(0), opb_q} >> DIGIT);
               res_sr_q <= res_next_c;
               carry_q  <= dcout;
               cnt_q    <= cnt_q + CNT_W'(1);
               // Publish on the final digit so the DONE cycle shows the new values
               if (last_c) begin
                  result         <= res_next_c;
                  flags[FLAG_N]  <= res_next_c[WIDTH-1];
                  flags[FLAG_Z]  <= (res_next_c == '0);
                  flags[FLAG_C]  <= dcout;
                  flags[FLAG_V]  <= dcmsb ^ dcout;
                  done           <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Self-checking bench for serial_addsub_unit: directed WIDTH=8/DIGIT=2 cases
// plus a randomised sweep over several WIDTH/DIGIT builds against a model.
module tb_serial_addsub_unit;

   localparam int NCFG = 9;

   function automatic int unsigned cfg_w(input int i);
      case (i)
         0, 1, 2: return 4;
         3, 4, 5: return 8;
         default: return 16;
      endcase
   endfunction

   function automatic int unsigned cfg_d(input int i);
      case (i)
         0: return 1;
         1: return 2;
         2: return 4;
         3: return 1;
         4: return 2;
         5: return 8;
         6: return 1;
         7: return 2;
         default: return 16;
      endcase
   endfunction

   logic       clk = 1'b0;
   logic       rst;
   logic       start, op;
   logic [7:0] a, b;
   logic       ready, done;
   logic [7:0] result;
   logic [3:0] flags;

   logic        st_s, op_s;
   logic [15:0] a_s, b_s;
   logic [15:0] sw_res   [NCFG];
   logic [3:0]  sw_flg   [NCFG];
   logic        sw_done  [NCFG];
   logic        sw_ready [NCFG];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   serial_addsub_unit #(.WIDTH(8), .DIGIT(2)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .ready  (ready),
      .done   (done),
      .result (result),
      .flags  (flags)
   );

   for (genvar gi = 0; gi < NCFG; gi++) begin : g_sw
      localparam int unsigned W = cfg_w(gi);
      localparam int unsigned D = cfg_d(gi);
      logic [W-1:0] r;
      logic [3:0]   f;
      logic         dn, rd;
      serial_addsub_unit #(.WIDTH(W), .DIGIT(D)) u (
         .clk    (clk),
         .rst    (rst),
         .start  (st_s),
         .op     (op_s),
         .a      (a_s[W-1:0]),
         .b      (b_s[W-1:0]),
         .ready  (rd),
         .done   (dn),
         .result (r),
         .flags  (f)
      );
      assign sw_res[gi]   = 16'(r);
      assign sw_flg[gi]   = f;
      assign sw_done[gi]  = dn;
      assign sw_ready[gi] = rd;
   end

   // Reference: plain integer arithmetic and the textbook signed-overflow rule
   function automatic void model(input int unsigned w, input logic o,
                                 input logic [15:0] x, input logic [15:0] y,
                                 output logic [15:0] r, output logic [3:0] f);
      longint unsigned m, xa, yb, full, rr;
      logic sa, sb, sr, c, v;
      m    = (64'd1 << w) - 64'd1;
      xa   = 64'(x) & m;
      yb   = 64'(y) & m;
      full = o ? (xa + ((~yb) & m) + 64'd1) : (xa + yb);
      rr   = full & m;
      c    = ((full >> w) & 64'd1) != 0;
      sa   = ((xa >> (w - 1)) & 64'd1) != 0;
      sb   = ((yb >> (w - 1)) & 64'd1) != 0;
      sr   = ((rr >> (w - 1)) & 64'd1) != 0;
      v    = o ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
      r    = 16'(rr);
      f    = {v, c, (rr == 0), sr};
   endfunction

   // Drives one op on the 8-bit unit from a negedge with ready=1; returns at the
   // negedge where ready is back. repulse_at>0 pulses a second start mid-run.
   task automatic do_op(input logic o, input logic [7:0] x, input logic [7:0] y,
                        input int repulse_at,
                        output logic [7:0] r, output logic [3:0] f,
                        output int done_at, output int n_done,
                        output int rdy_err, output int hold_err);
      logic [7:0] prev;
      r = 'x; f = 'x; done_at = -1; n_done = 0; rdy_err = 0; hold_err = 0;
      prev  = result;
      op    = o; a = x; b = y; start = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 1) begin
            start = 1'b0; a = 8'($urandom); b = 8'($urandom); op = 1'($urandom);
         end
         if (repulse_at > 0 && i == repulse_at) begin
            start = 1'b1; op = 1'b0; a = 8'hFF; b = 8'h01;
         end else if (repulse_at > 0 && i == repulse_at + 1) begin
            start = 1'b0;
         end
         if (done) begin
            n_done++; done_at = i; r = result; f = flags;
         end else if (result !== prev) begin
            hold_err++;
         end
         prev = result;
         if (i < 6 && ready !== 1'b0) rdy_err++;
         if (i >= 6) begin
            if (ready === 1'b1) break;
            rdy_err++;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
      st_s = 1'b0; op_s = 1'b0; a_s = '0; b_s = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", ready); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
      n_checks++; if (result !== 8'h00) begin n_fail++; $display("FAIL reset_result got=%h exp=00", result); end
      n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got=%b exp=0000", flags); end
   endtask

   task automatic test_sub_timing();
      logic [7:0] r; logic [3:0] f; int da, nd, re, he;
      do_op(1'b1, 8'h05, 8'h03, 0, r, f, da, nd, re, he);
      n_checks++; if (r !== 8'h02) begin n_fail++; $display("FAIL sub_5_3_result got=%h exp=02", r); end
      n_checks++; if (f !== 4'b0100) begin n_fail++; $display("FAIL sub_5_3_flags got=%b exp=0100", f); end
      n_checks++; if (da !== 5) begin n_fail++; $display("FAIL sub_5_3_done_cycle got=%0d exp=5", da); end
      n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL sub_5_3_done_count got=%0d exp=1", nd); end
      n_checks++; if (re !== 0) begin n_fail++; $display("FAIL sub_5_3_ready_window errors=%0d exp=0", re); end
      n_checks++; if (he !== 0) begin n_fail++; $display("FAIL sub_5_3_result_hold changes=%0d exp=0", he); end
   endtask

   task automatic test_directed();
      logic [7:0] r; logic [3:0] f; int da, nd, re, he;
      logic       t_op [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [7:0] t_a  [5] = '{8'h03, 8'h80, 8'h7F, 8'hFF, 8'h5A};
      logic [7:0] t_b  [5] = '{8'h05, 8'h01, 8'h01, 8'h01, 8'h5A};
      logic [7:0] t_r  [5] = '{8'hFE, 8'h7F, 8'h80, 8'h00, 8'h00};
      logic [3:0] t_f  [5] = '{4'b0001, 4'b1100, 4'b1001, 4'b0110, 4'b0110};
      for (int k = 0; k < 5; k++) begin
         do_op(t_op[k], t_a[k], t_b[k], 0, r, f, da, nd, re, he);
         n_checks++; if (r !== t_r[k]) begin n_fail++; $display("FAIL directed%0d_result got=%h exp=%h", k, r, t_r[k]); end
         n_checks++; if (f !== t_f[k]) begin n_fail++; $display("FAIL directed%0d_flags got=%b exp=%b", k, f, t_f[k]); end
         n_checks++; if (da !== 5 || re !== 0) begin n_fail++; $display("FAIL directed%0d_timing done_at=%0d ready_err=%0d exp=5/0", k, da, re); end
      end
   endtask

   task automatic test_restart_ignored();
      logic [7:0] r; logic [3:0] f; int da, nd, re, he, extra;
      do_op(1'b1, 8'h05, 8'h03, 2, r, f, da, nd, re, he);
      n_checks++; if (r !== 8'h02) begin n_fail++; $display("FAIL restart_result got=%h exp=02", r); end
      n_checks++; if (f !== 4'b0100) begin n_fail++; $display("FAIL restart_flags got=%b exp=0100", f); end
      n_checks++; if (nd !== 1 || da !== 5) begin n_fail++; $display("FAIL restart_done count=%0d at=%0d exp=1/5", nd, da); end
      extra = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done !== 1'b0 || ready !== 1'b1) extra++;
      end
      n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL restart_no_queue events=%0d exp=0", extra); end
   endtask

   task automatic test_reset_midrun();
      int bad;
      op = 1'b0; a = 8'h11; b = 8'h22; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got=%b exp=1", ready); end
      n_checks++; if (result !== 8'h00) begin n_fail++; $display("FAIL midrst_result got=%h exp=00", result); end
      n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL midrst_flags got=%b exp=0000", flags); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got=%b exp=0", done); end
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done !== 1'b0 || ready !== 1'b1 || result !== 8'h00) bad++;
      end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL midrst_aborted events=%0d exp=0", bad); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] r, x, y; logic [3:0] f; logic o; int da, nd, re, he;
      logic [15:0] er; logic [3:0] ef;
      for (int k = 0; k < 8; k++) begin
         o = 1'($urandom); x = 8'($urandom); y = 8'($urandom);
         model(8, o, 16'(x), 16'(y), er, ef);
         do_op(o, x, y, 0, r, f, da, nd, re, he);
         n_checks++; if (r !== er[7:0]) begin n_fail++; $display("FAIL b2b%0d_result op=%b a=%h b=%h got=%h exp=%h", k, o, x, y, r, er[7:0]); end
         n_checks++; if (f !== ef) begin n_fail++; $display("FAIL b2b%0d_flags op=%b a=%h b=%h got=%b exp=%b", k, o, x, y, f, ef); end
         n_checks++; if (da !== 5 || re !== 0 || he !== 0) begin n_fail++; $display("FAIL b2b%0d_timing done_at=%0d ready_err=%0d hold_err=%0d", k, da, re, he); end
      end
   endtask

   task automatic test_sweep();
      int          dn_at [NCFG];
      int          cnt   [NCFG];
      logic [15:0] cr    [NCFG];
      logic [3:0]  cf    [NCFG];
      logic [15:0] xa, yb, er;
      logic [3:0]  ef;
      logic        o;
      for (int it = 0; it < 40; it++) begin
         o  = 1'($urandom);
         xa = 16'($urandom);
         yb = 16'($urandom);
         if (it == 0) begin xa = 16'hFFFF; yb = 16'h0001; o = 1'b0; end
         if (it == 1) begin xa = 16'h8888; yb = 16'h0101; o = 1'b1; end
         if (it == 2) begin xa = 16'h7777; yb = 16'h0101; o = 1'b0; end
         if (it == 3) begin xa = 16'h1234; yb = 16'h1234; o = 1'b1; end
         for (int c = 0; c < NCFG; c++) begin dn_at[c] = -1; cnt[c] = 0; cr[c] = 'x; cf[c] = 'x; end
         op_s = o; a_s = xa; b_s = yb; st_s = 1'b1;
         for (int i = 1; i <= 19; i++) begin
            @(negedge clk);
            if (i == 1) begin st_s = 1'b0; a_s = 16'($urandom); b_s = 16'($urandom); op_s = ~o; end
            for (int c = 0; c < NCFG; c++) begin
               if (sw_done[c]) begin cnt[c]++; dn_at[c] = i; cr[c] = sw_res[c]; cf[c] = sw_flg[c]; end
            end
         end
         for (int c = 0; c < NCFG; c++) begin
            model(cfg_w(c), o, xa, yb, er, ef);
            n_checks++; if (cr[c] !== er) begin n_fail++; $display("FAIL sweep_w%0d_d%0d_result op=%b a=%h b=%h got=%h exp=%h", cfg_w(c), cfg_d(c), o, xa, yb, cr[c], er); end
            n_checks++; if (cf[c] !== ef) begin n_fail++; $display("FAIL sweep_w%0d_d%0d_flags op=%b a=%h b=%h got=%b exp=%b", cfg_w(c), cfg_d(c), o, xa, yb, cf[c], ef); end
            n_checks++; if (cnt[c] !== 1 || dn_at[c] !== int'(cfg_w(c) / cfg_d(c)) + 1 || sw_ready[c] !== 1'b1) begin
               n_fail++; $display("FAIL sweep_w%0d_d%0d_timing done_count=%0d done_at=%0d ready=%b exp=1/%0d/1", cfg_w(c), cfg_d(c), cnt[c], dn_at[c], sw_ready[c], cfg_w(c) / cfg_d(c) + 1);
            end
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_sub_timing();
      test_directed();
      test_restart_ignored();
      test_reset_midrun();
      test_back_to_back();
      test_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
